// File: rtl/flow_ctrl_pkg.sv
// Shared types for the pipeline flow-control unit: FSM states, per-stage control pair,
// and the hard-wired zero register index.
package flow_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED,
        STEP
    } flow_state_t;

    typedef struct packed {
        logic we;
        logic flush;
    } stage_ctrl_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_flow_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source operands of the instruction in ID.
module hazard_detect
    import flow_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    always_comb begin
        load_use = ex_mem_read && (ex_rd != REG_X0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Hazard/flow-control unit: stall and flush enables for PC and pipeline registers, debug halt/step.
// Optional stall/flush counters are built when FLOW_CTRL_STATS_EN is defined.
module pipeline_flow_ctrl
    import flow_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4
`ifdef FLOW_CTRL_STATS_EN
   ,parameter int unsigned CNT_W        = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_redirect_i,
    input  logic       dmem_busy_i,
    input  logic       halt_req_i,
    input  logic       step_req_i,
    output logic       pc_we_o,
    output logic       if_id_we_o,
    output logic       id_ex_we_o,
    output logic       ex_mem_we_o,
    output logic       mem_wb_we_o,
    output logic       if_id_flush_o,
    output logic       id_ex_flush_o,
    output logic       ex_mem_flush_o,
    output logic       mem_wb_flush_o,
    output logic       halted_o
`ifdef FLOW_CTRL_STATS_EN
   ,output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    flow_state_t        state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               load_use;
    logic               pc_we;
    stage_ctrl_t        if_id, id_ex, ex_mem, mem_wb;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1_i),
        .id_rs2      (id_rs2_i),
        .id_uses_rs1 (id_uses_rs1_i),
        .id_uses_rs2 (id_uses_rs2_i),
        .ex_rd       (ex_rd_i),
        .ex_mem_read (ex_mem_read_i),
        .load_use    (load_use)
    );

    always_comb begin
        pc_we  = 1'b1;
        if_id  = '{we: 1'b1, flush: 1'b0};
        id_ex  = '{we: 1'b1, flush: 1'b0};
        ex_mem = '{we: 1'b1, flush: 1'b0};
        mem_wb = '{we: 1'b1, flush: 1'b0};
        unique case (state)
            RUN, STEP: begin
                if (dmem_busy_i) begin
                    pc_we        = 1'b0;
                    if_id.we     = 1'b0;
                    id_ex.we     = 1'b0;
                    ex_mem.we    = 1'b0;
                    mem_wb.flush = 1'b1;
                end else if (ex_redirect_i) begin
                    if_id.flush  = 1'b1;
                    id_ex.flush  = 1'b1;
                end else if (load_use) begin
                    pc_we        = 1'b0;
                    if_id.we     = 1'b0;
                    id_ex.flush  = 1'b1;
                end
            end
            DRAIN: begin
                pc_we = 1'b0;
                // A memory wait freezes IF/ID too, so the live ID instruction is not lost to the drain flush.
                if (dmem_busy_i) begin
                    if_id.we     = 1'b0;
                    id_ex.we     = 1'b0;
                    ex_mem.we    = 1'b0;
                    mem_wb.flush = 1'b1;
                end else begin
                    if_id.flush = 1'b1;
                    if (ex_redirect_i) begin
                        pc_we       = 1'b1;
                        id_ex.flush = 1'b1;
                    end
                end
            end
            HALTED: begin
                pc_we     = 1'b0;
                if_id.we  = 1'b0;
                id_ex.we  = 1'b0;
                ex_mem.we = 1'b0;
                mem_wb.we = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (halt_req_i) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (!dmem_busy_i) begin
                        if (ex_redirect_i) begin
                            drain_cnt <= DRAIN_LOAD;
                        end else if (drain_cnt <= DRAIN_W'(1)) begin
                            drain_cnt <= '0;
                            state     <= HALTED;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_W'(1);
                        end
                    end
                end
                HALTED: begin
                    if (!halt_req_i) begin
                        state <= RUN;
                    end else if (step_req_i) begin
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (!dmem_busy_i) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign pc_we_o        = pc_we;
    assign if_id_we_o     = if_id.we;
    assign id_ex_we_o     = id_ex.we;
    assign ex_mem_we_o    = ex_mem.we;
    assign mem_wb_we_o    = mem_wb.we;
    assign if_id_flush_o  = if_id.flush;
    assign id_ex_flush_o  = id_ex.flush;
    assign ex_mem_flush_o = ex_mem.flush;
    assign mem_wb_flush_o = mem_wb.flush;
    assign halted_o       = (state == HALTED);

`ifdef FLOW_CTRL_STATS_EN
    logic stall_evt, flush_evt;

    always_comb begin
        stall_evt = (state != HALTED) &&
                    (dmem_busy_i || (((state == RUN) || (state == STEP)) && load_use && !ex_redirect_i));
        flush_evt = (state != HALTED) && !dmem_busy_i && ex_redirect_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_evt && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed-vector bench for pipeline_flow_ctrl: hazards, priorities, halt/drain/step, async reset.
module tb_pipeline_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, dmem_busy, halt_req, step_req;
    logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted;
`ifdef FLOW_CTRL_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    // Packed view: {pc, if_id, id_ex, ex_mem, mem_wb we} {if_id, id_ex, ex_mem, mem_wb flush} {halted}
    localparam logic [9:0] V_IDLE  = 10'b11111_0000_0;
    localparam logic [9:0] V_LU    = 10'b00111_0100_0;
    localparam logic [9:0] V_RED   = 10'b11111_1100_0;
    localparam logic [9:0] V_BUSY  = 10'b00001_0001_0;
    localparam logic [9:0] V_DRAIN = 10'b01111_1000_0;
    localparam logic [9:0] V_HALT  = 10'b00000_0000_1;

    logic [9:0]  obs;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    assign obs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted};

    always #5 clk = ~clk;

    pipeline_flow_ctrl #(.DRAIN_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_uses_rs1_i  (id_uses_rs1),
        .id_uses_rs2_i  (id_uses_rs2),
        .ex_rd_i        (ex_rd),
        .ex_mem_read_i  (ex_mem_read),
        .ex_redirect_i  (ex_redirect),
        .dmem_busy_i    (dmem_busy),
        .halt_req_i     (halt_req),
        .step_req_i     (step_req),
        .pc_we_o        (pc_we),
        .if_id_we_o     (if_id_we),
        .id_ex_we_o     (id_ex_we),
        .ex_mem_we_o    (ex_mem_we),
        .mem_wb_we_o    (mem_wb_we),
        .if_id_flush_o  (if_id_flush),
        .id_ex_flush_o  (id_ex_flush),
        .ex_mem_flush_o (ex_mem_flush),
        .mem_wb_flush_o (mem_wb_flush),
        .halted_o       (halted)
`ifdef FLOW_CTRL_STATS_EN
       ,.stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs are already set (posedge+1); sample mid-cycle, then move past the next edge.
    task automatic tick(input string tag, input logic [9:0] exp);
        @(negedge clk);
        check_eq(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; dmem_busy = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #3;
        check_eq("reset", obs, V_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tick("run_idle", V_IDLE);

        // load-use on rs1, then the bubble has reached EX
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        tick("lu_rs1", V_LU);
        ex_mem_read = 1'b0;
        tick("lu_after", V_IDLE);

        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_rs1 = 5'd1;
        tick("lu_rs2", V_LU);
        id_uses_rs2 = 1'b0; id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
        tick("lu_no_use", V_IDLE);

        ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        tick("lu_x0", V_IDLE);

        ex_rd = 5'd5; id_rs1 = 5'd5;
        ex_redirect = 1'b1;
        tick("redir_over_lu", V_RED);
        ex_redirect = 1'b0;

        dmem_busy = 1'b1;
        tick("busy_over_lu", V_BUSY);
        dmem_busy = 1'b0;
        tick("lu_after_busy", V_LU);
        idle_inputs();

        ex_redirect = 1'b1; dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) tick("busy_redir", V_BUSY);
        dmem_busy = 1'b0;
        tick("redir_after_busy", V_RED);
        ex_redirect = 1'b0;

        // halt and drain
        halt_req = 1'b1;
        tick("halt_run", V_IDLE);
        for (int i = 0; i < 4; i++) tick("drain", V_DRAIN);
        tick("halted", V_HALT);

        // single step
        step_req = 1'b1;
        tick("step_req", V_HALT);
        step_req = 1'b0;
        tick("step_fetch", V_IDLE);
        for (int i = 0; i < 4; i++) tick("step_drain", V_DRAIN);
        tick("step_halted", V_HALT);

        halt_req = 1'b0;
        tick("resume", V_HALT);
        tick("resumed", V_IDLE);

        // drain stretched by two busy cycles; dropping halt_req does not abort it
        halt_req = 1'b1;
        tick("halt2_run", V_IDLE);
        tick("drain2_c1", V_DRAIN);
        tick("drain2_c2", V_DRAIN);
        dmem_busy = 1'b1;
        tick("drain2_busy", V_BUSY);
        tick("drain2_busy", V_BUSY);
        dmem_busy = 1'b0; halt_req = 1'b0;
        tick("drain2_c5", V_DRAIN);
        tick("drain2_c6", V_DRAIN);
        tick("halted2_c7", V_HALT);
        tick("resumed2", V_IDLE);

        // redirect during drain reloads the count
        halt_req = 1'b1;
        tick("halt3_run", V_IDLE);
        tick("drain3", V_DRAIN);
        ex_redirect = 1'b1;
        tick("drain3_redir", V_RED);
        ex_redirect = 1'b0;
        for (int i = 0; i < 4; i++) tick("drain3_reload", V_DRAIN);
        tick("halted3", V_HALT);

        // asynchronous reset in the middle of a drain
        halt_req = 1'b0;
        tick("resume3", V_HALT);
        halt_req = 1'b1;
        tick("halt4_run", V_IDLE);
        tick("drain4", V_DRAIN);
        rst_n = 1'b0; halt_req = 1'b0;
        #1;
        check_eq("async_reset", obs, V_IDLE);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick("post_reset", V_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
